keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_decode.sv | 41 ++++
 rtl/keypad_scanner.sv | 92 +++++++++
 tb/tb_keypad_scanner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared state encoding, row-drive constants and column helpers for the keypad scanner.
package keypad_pkg;

  // Even encodings scan a row; odd encodings hold that row while a press is handled
  localparam logic [2:0] ST_ROW1 = 3'd0;
  localparam logic [2:0] ST_R1P  = 3'd1;
  localparam logic [2:0] ST_ROW2 = 3'd2;
  localparam logic [2:0] ST_R2P  = 3'd3;
  localparam logic [2:0] ST_ROW3 = 3'd4;
  localparam logic [2:0] ST_R3P  = 3'd5;
  localparam logic [2:0] ST_ROW4 = 3'd6;
  localparam logic [2:0] ST_R4P  = 3'd7;

  localparam logic [3:0] ROW1_DRV = 4'b1000;
  localparam logic [3:0] ROW2_DRV = 4'b0100;
  localparam logic [3:0] ROW3_DRV = 4'b0010;
  localparam logic [3:0] ROW4_DRV = 4'b0001;

  localparam logic [3:0] COLS_IDLE = 4'b1111;

  function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
    case (row_idx)
      2'd0:    return ROW1_DRV;
      2'd1:    return ROW2_DRV;
      2'd2:    return ROW3_DRV;
      default: return ROW4_DRV;
    endcase
  endfunction

  // Index 0 is col1 (columns[3]); the lowest-numbered low column wins
  function automatic logic [1:0] first_low_col(input logic [3:0] cols);
    casez (cols)
      4'b0???: return 2'd0;
      4'b10??: return 2'd1;
      4'b110?: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Maps a one-hot row drive and a column index (0 = col1) to the printed hex key code.
// Purely combinational; an unrecognised row pattern decodes to 0.
module keypad_decode (
  input  logic [3:0] row_onehot,
  input  logic [1:0] col_idx,
  output logic [3:0] code
);
  import keypad_pkg::*;

  always_comb begin
    code = 4'h0;
    case (row_onehot)
      ROW1_DRV: case (col_idx)
        2'd0: code = 4'h1;
        2'd1: code = 4'h2;
        2'd2: code = 4'h3;
        default: code = 4'hA;
      endcase
      ROW2_DRV: case (col_idx)
        2'd0: code = 4'h4;
        2'd1: code = 4'h5;
        2'd2: code = 4'h6;
        default: code = 4'hB;
      endcase
      ROW3_DRV: case (col_idx)
        2'd0: code = 4'h7;
        2'd1: code = 4'h8;
        2'd2: code = 4'h9;
        default: code = 4'hC;
      endcase
      ROW4_DRV: case (col_idx)
        2'd0: code = 4'hE;
        2'd1: code = 4'h0;
        2'd2: code = 4'hF;
        default: code = 4'hD;
      endcase
      default: code = 4'h0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates one-hot row drive, debounces press and release, registers the key code.
// A press is accepted DEBOUNCE_CYCLES+1 clocks after it is first seen; no flow control, one pulse per press.
module keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] value,
  output logic       key_pressed
);
  import keypad_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0]    state;
  logic [1:0]    col_idx;
  logic [CW-1:0] count;
  logic          accepted;
  logic [3:0]    code;
  logic [3:0]    col_mask;
  logic          latched_low;
  logic [CW-1:0] count_inc;
  logic          count_done;
  logic [1:0]    next_row;

  assign rows        = row_drive(state[2:1]);
  assign col_mask    = 4'b1000 >> col_idx;
  assign latched_low = ((columns & col_mask) == 4'b0000);
  assign count_inc   = count + CW'(1);
  assign count_done  = (count_inc == CW'(DEBOUNCE_CYCLES));
  assign next_row    = state[2:1] + 2'd1;

  keypad_decode u_decode (
    .row_onehot (rows),
    .col_idx    (col_idx),
    .code       (code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ROW1;
      col_idx     <= 2'd0;
      count       <= '0;
      accepted    <= 1'b0;
      value       <= 4'h0;
      key_pressed <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      if (!state[0]) begin
        if (columns == COLS_IDLE) begin
          state <= {next_row, 1'b0};
        end else begin
          state    <= {state[2:1], 1'b1};
          col_idx  <= first_low_col(columns);
          count    <= '0;
          accepted <= 1'b0;
        end
      end else if (!accepted) begin
        // Only the latched column matters; other columns are ignored while debouncing
        if (latched_low) begin
          if (count_done) begin
            value       <= code;
            key_pressed <= 1'b1;
            accepted    <= 1'b1;
            count       <= '0;
          end else begin
            count <= count_inc;
          end
        end else begin
          state <= {state[2:1], 1'b0};
          count <= '0;
        end
      end else begin
        // Release needs an unbroken run of idle columns; any low column restarts it
        if (columns == COLS_IDLE) begin
          if (count_done) begin
            state    <= {next_row, 1'b0};
            accepted <= 1'b0;
            count    <= '0;
          end else begin
            count <= count_inc;
          end
        end else begin
          count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: key codes are queued when a press is driven and checked by a monitor on each key_pressed pulse.
module tb_keypad_scanner;

  localparam int D = 3;

  logic       clk;
  logic       reset;
  logic [3:0] columns;
  logic [3:0] rows;
  logic [3:0] value;
  logic       key_pressed;

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .columns     (columns),
    .rows        (rows),
    .value       (value),
    .key_pressed (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest queued key code
  always @(negedge clk) begin
    if (!reset && key_pressed === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL pulse: unexpected key_pressed with value %h, expected no pulse", value);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (value !== e) begin
          n_miss++;
          $display("FAIL pulse_value: got %h, expected %h", value, e);
        end
      end
    end
  end

  // Called on a negedge with the scanner sitting on the target row
  task automatic press(input logic [3:0] cols, input logic [3:0] code, input logic [3:0] row_exp);
    columns = cols;
    exp_q.push_back(code);
    @(negedge clk);
    check("press_row_hold", rows, row_exp);
    for (int i = 0; i < D; i++) begin
      check("no_early_pulse", {3'b000, key_pressed}, 4'b0000);
      @(negedge clk);
    end
    check("pulse_timing", {3'b000, key_pressed}, 4'b0001);
    check("value_latched", value, code);
  endtask

  task automatic hold_and_release(input logic [3:0] row_held, input logic [3:0] row_next);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("held_row", rows, row_held);
    columns = 4'b1111;
    for (int i = 0; i < D - 1; i++) begin
      @(negedge clk);
      check("release_row_hold", rows, row_held);
    end
    @(negedge clk);
    check("release_next_row", rows, row_next);
  endtask

  initial begin
    reset   = 1'b1;
    columns = 4'b1111;
    #12;
    check("reset_rows", rows, 4'b1000);
    check("reset_value", value, 4'h0);
    check("reset_pulse", {3'b000, key_pressed}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    check("scan_row1", rows, 4'b1000);
    @(negedge clk); check("scan_row2", rows, 4'b0100);
    @(negedge clk); check("scan_row3", rows, 4'b0010);
    @(negedge clk); check("scan_row4", rows, 4'b0001);
    @(negedge clk); check("scan_wrap", rows, 4'b1000);
    check("scan_value", value, 4'h0);

    press(4'b0111, 4'h1, 4'b1000);
    hold_and_release(4'b1000, 4'b0100);
    press(4'b1011, 4'h5, 4'b0100);
    hold_and_release(4'b0100, 4'b0010);
    press(4'b1101, 4'h9, 4'b0010);
    hold_and_release(4'b0010, 4'b0001);
    press(4'b1110, 4'hD, 4'b0001);
    hold_and_release(4'b0001, 4'b1000);

    // One-cycle bounce on row1 must return to ROW1 with no value change
    columns = 4'b0111;
    @(negedge clk);
    check("bounce_hold", rows, 4'b1000);
    columns = 4'b1111;
    @(negedge clk);
    check("bounce_return", rows, 4'b1000);
    check("bounce_value", value, 4'hD);
    @(negedge clk);
    check("bounce_next_row", rows, 4'b0100);

    press(4'b0011, 4'h4, 4'b0100);

    // Reset mid-press, sampled without any clock edge in between
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_rows", rows, 4'b1000);
    check("async_reset_value", value, 4'h0);
    check("async_reset_pulse", {3'b000, key_pressed}, 4'b0000);
    columns = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_scan", rows, 4'b0100);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL missing_pulses: %0d queued keys never pulsed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
